// File: rtl/rv_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
interface rv_lsu_if #(
    parameter int XLEN = 32
);
    logic              data_read_out;
    logic              data_write_out;
    logic [XLEN/8-1:0] data_write_mask_out;
    logic [XLEN-1:0]   data_address_out;
    logic [XLEN-1:0]   data_write_value_out;
    logic [XLEN-1:0]   data_read_value_in;
    logic              data_ready_in;

    modport master (
        output data_read_out,
        output data_write_out,
        output data_write_mask_out,
        output data_address_out,
        output data_write_value_out,
        input  data_read_value_in,
        input  data_ready_in
    );

    modport slave (
        input  data_read_out,
        input  data_write_out,
        input  data_write_mask_out,
        input  data_address_out,
        input  data_write_value_out,
        output data_read_value_in,
        output data_ready_in
    );
endinterface

// File: rtl/rv_lsu.sv
// Load/store stage: IDLE/WAIT/DONE bus sequencer with lane steering.
// Define RV_LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module rv_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            valid_in,
    input  logic            read_in,
    input  logic            write_in,
    input  logic [1:0]      width_in,
    input  logic            zero_extend_in,
    input  logic [4:0]      rd_in,
    input  logic            rd_write_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] rs2_value_in,
    rv_lsu_if.master        bus,
    output logic            valid_out,
    output logic [4:0]      rd_out,
    output logic            rd_write_out,
    output logic [XLEN-1:0] rd_value_out,
    output logic            busy_out,
    output logic            misaligned_out
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    function automatic int unsigned acc_bytes(input logic [1:0] w);
        unique case (w)
            2'b01:   acc_bytes = 2;
            2'b10:   acc_bytes = 1;
            2'b11:   acc_bytes = (XLEN == 64) ? 8 : 4;
            default: acc_bytes = 4;
        endcase
    endfunction

    function automatic logic [LB-1:0] size_mask(input logic [1:0] w);
        size_mask = LB'(acc_bytes(w) - 1);
    endfunction

    function automatic logic [NB-1:0] lane_mask(
        input logic [LB-1:0] off,
        input logic [1:0]    w
    );
        lane_mask = NB'((32'd1 << acc_bytes(w)) - 32'd1) << off;
    endfunction

    function automatic logic [XLEN-1:0] lane_data(
        input logic [XLEN-1:0] d,
        input logic [1:0]      w
    );
        unique case (w)
            2'b01:   lane_data = {(NB/2){d[15:0]}};
            2'b10:   lane_data = {NB{d[7:0]}};
            2'b11:   lane_data = d;
            default: lane_data = {(XLEN/32){d[31:0]}};
        endcase
    endfunction

    // keep covers the access width; its top bit picks the sign
    function automatic logic [XLEN-1:0] load_fmt(
        input logic [XLEN-1:0] d,
        input logic [LB-1:0]   off,
        input logic [1:0]      w,
        input logic            zx
    );
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] keep;
        logic            sgn;
        s        = d >> {off, 3'b000};
        keep     = ~({XLEN{1'b1}} << (acc_bytes(w) * 8));
        sgn      = !zx && |(s & keep & ~(keep >> 1));
        load_fmt = (s & keep) | ({XLEN{sgn}} & ~keep);
    endfunction

    state_t state, state_nx;

    logic            q_read, q_write, q_zx, q_rd_write, kill;
    logic [1:0]      q_width;
    logic [4:0]      q_rd;
    logic [XLEN-1:0] q_addr, q_wdata, done_value;
    logic [NB-1:0]   q_mask;
    logic [LB-1:0]   q_off;

    logic            mem_op, misalign, issue, wait_req, kill_now, ld;
    logic [LB-1:0]   in_off;
    logic            nx_valid, nx_rd_write;
    logic [4:0]      nx_rd;
    logic [XLEN-1:0] nx_value, wait_value;

    assign mem_op = valid_in & (read_in | write_in);
    assign in_off = result_in[LB-1:0] & ~size_mask(width_in);

`ifdef RV_LSU_MISALIGN_TRAP_EN
    assign misalign = mem_op
                    & |(result_in[LB-1:0] & size_mask(width_in));
`else
    assign misalign = 1'b0;
`endif

    assign issue = !reset && state == IDLE && mem_op && !stall_in
                 && !flush_in && !misalign;
    assign wait_req   = !reset && state == WAIT;
    assign kill_now   = kill | flush_in;
    assign busy_out   = (issue | wait_req) & !bus.data_ready_in;
    assign wait_value = q_read
        ? load_fmt(bus.data_read_value_in, q_off, q_width, q_zx)
        : q_addr;

    always_comb begin
        bus.data_read_out        = 1'b0;
        bus.data_write_out       = 1'b0;
        bus.data_write_mask_out  = '0;
        bus.data_address_out     = '0;
        bus.data_write_value_out = '0;
        if (wait_req) begin
            bus.data_read_out        = q_read;
            bus.data_write_out       = q_write;
            bus.data_write_mask_out  = q_mask;
            bus.data_address_out     = q_addr;
            bus.data_write_value_out = q_wdata;
        end else if (issue) begin
            bus.data_read_out        = read_in;
            bus.data_write_out       = write_in;
            bus.data_write_mask_out  = lane_mask(in_off, width_in);
            bus.data_address_out     = result_in;
            bus.data_write_value_out = lane_data(rs2_value_in, width_in);
        end
    end

    always_comb begin
        state_nx    = state;
        ld          = 1'b0;
        nx_valid    = 1'b0;
        nx_rd       = q_rd;
        nx_rd_write = 1'b0;
        nx_value    = wait_value;
        unique case (state)
            IDLE: begin
                nx_rd    = rd_in;
                nx_value = result_in;
                if (flush_in) begin
                    ld = 1'b1;
                end else if (!stall_in) begin
                    ld          = 1'b1;
                    nx_valid    = valid_in;
                    nx_rd_write = rd_write_in & !misalign;
                    if (issue && read_in)
                        nx_value = load_fmt(bus.data_read_value_in,
                                            in_off, width_in,
                                            zero_extend_in);
                    if (issue && !bus.data_ready_in) begin
                        state_nx    = WAIT;
                        nx_valid    = 1'b0;
                        nx_rd_write = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (bus.data_ready_in) begin
                    if (stall_in) begin
                        state_nx = DONE;
                    end else begin
                        ld          = 1'b1;
                        state_nx    = IDLE;
                        nx_valid    = !kill_now;
                        nx_rd_write = q_rd_write & !kill_now;
                    end
                end
            end
            DONE: begin
                if (!stall_in) begin
                    ld          = 1'b1;
                    state_nx    = IDLE;
                    nx_valid    = !kill_now;
                    nx_rd_write = q_rd_write & !kill_now;
                    nx_value    = done_value;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out    <= 1'b0;
            rd_out       <= '0;
            rd_write_out <= 1'b0;
            rd_value_out <= '0;
        end else if (ld) begin
            valid_out    <= nx_valid;
            rd_out       <= nx_rd;
            rd_write_out <= nx_rd_write;
            rd_value_out <= nx_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kill       <= 1'b0;
            q_read     <= 1'b0;
            q_write    <= 1'b0;
            q_zx       <= 1'b0;
            q_rd_write <= 1'b0;
            q_width    <= '0;
            q_rd       <= '0;
            q_addr     <= '0;
            q_wdata    <= '0;
            q_mask     <= '0;
            q_off      <= '0;
            done_value <= '0;
        end else begin
            if (issue) begin
                kill       <= 1'b0;
                q_read     <= read_in;
                q_write    <= write_in;
                q_zx       <= zero_extend_in;
                q_rd_write <= rd_write_in;
                q_width    <= width_in;
                q_rd       <= rd_in;
                q_addr     <= result_in;
                q_wdata    <= lane_data(rs2_value_in, width_in);
                q_mask     <= lane_mask(in_off, width_in);
                q_off      <= in_off;
            end else if (state != IDLE && flush_in) begin
                kill <= 1'b1;
            end
            if (state == WAIT && bus.data_ready_in && stall_in)
                done_value <= wait_value;
        end
    end

`ifdef RV_LSU_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clk) begin
        if (reset)
            mis_q <= 1'b0;
        else if (ld)
            mis_q <= (state == IDLE) & !flush_in & misalign;
    end

    assign misaligned_out = mis_q;
`else
    assign misaligned_out = 1'b0;
`endif
endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu, XLEN=32 and XLEN=64 instances side by side.
// Misaligned-access expectations follow RV_LSU_MISALIGN_TRAP_EN.
module tb_rv_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid, rd_en, wr_en, zx, rdw;
    logic [1:0]  width;
    logic [4:0]  rd;
    logic [31:0] result, rs2;
    logic [63:0] result64, rs2_64;

    logic        valid32, rdw32, busy32, mis32;
    logic [4:0]  rd32;
    logic [31:0] val32;
    logic        valid64, rdw64, busy64, mis64;
    logic [4:0]  rd64;
    logic [63:0] val64;

    int total = 0;
    int passed = 0;
    int fails = 0;

    rv_lsu_if #(.XLEN(32)) b32 ();
    rv_lsu_if #(.XLEN(64)) b64 ();

    rv_lsu #(.XLEN(32)) d32 (
        .clk(clk), .reset(reset),
        .stall_in(stall), .flush_in(flush),
        .valid_in(valid), .read_in(rd_en), .write_in(wr_en),
        .width_in(width), .zero_extend_in(zx),
        .rd_in(rd), .rd_write_in(rdw),
        .result_in(result), .rs2_value_in(rs2),
        .bus(b32),
        .valid_out(valid32), .rd_out(rd32),
        .rd_write_out(rdw32), .rd_value_out(val32),
        .busy_out(busy32), .misaligned_out(mis32)
    );

    rv_lsu #(.XLEN(64)) d64 (
        .clk(clk), .reset(reset),
        .stall_in(stall), .flush_in(flush),
        .valid_in(valid), .read_in(rd_en), .write_in(wr_en),
        .width_in(width), .zero_extend_in(zx),
        .rd_in(rd), .rd_write_in(rdw),
        .result_in(result64), .rs2_value_in(rs2_64),
        .bus(b64),
        .valid_out(valid64), .rd_out(rd64),
        .rd_write_out(rdw64), .rd_value_out(val64),
        .busy_out(busy64), .misaligned_out(mis64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic op(input logic v, input logic r, input logic w,
                      input logic [1:0] wd, input logic z,
                      input logic [4:0] d, input logic dw,
                      input logic [31:0] a, input logic [31:0] s);
        valid    = v;
        rd_en    = r;
        wr_en    = w;
        width    = wd;
        zx       = z;
        rd       = d;
        rdw      = dw;
        result   = a;
        rs2      = s;
        result64 = {32'h0, a};
        rs2_64   = {32'h0, s};
    endtask

    task automatic rsp(input logic rdy, input logic [31:0] v32,
                       input logic [63:0] v64);
        b32.data_ready_in      = rdy;
        b32.data_read_value_in = v32;
        b64.data_ready_in      = rdy;
        b64.data_read_value_in = v64;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        op(1, 1, 0, 2'b00, 0, 5'd1, 1, 32'h100, 0);
        rsp(0, 0, 0);
        @(negedge clk);
        chk("rst_bus_read", b32.data_read_out, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_mask", b32.data_write_mask_out, 0);
        tick;
        tick;
        chk("rst_valid", valid32, 0);
        chk("rst_rd", rd32, 0);
        chk("rst_rdw", rdw32, 0);
        chk("rst_value", val32, 0);
        chk("rst_mis", mis32, 0);
        reset = 1'b0;

        // LB 0x103, zero-wait
        op(1, 1, 0, 2'b10, 0, 5'd5, 1, 32'h103, 0);
        rsp(1, 32'h80FF_FF00, 64'h0);
        @(negedge clk);
        chk("lb_busy", busy32, 0);
        chk("lb_read", b32.data_read_out, 1);
        chk("lb_mask", b32.data_write_mask_out, 4'b1000);
        chk("lb_addr", b32.data_address_out, 32'h103);
        tick;
        chk("lb_valid", valid32, 1);
        chk("lb_rd", rd32, 5);
        chk("lb_rdw", rdw32, 1);
        chk("lb_value", val32, 32'hFFFF_FF80);
        chk("lb_busy_after", busy32, 0);

        op(1, 1, 0, 2'b10, 1, 5'd5, 1, 32'h103, 0);
        tick;
        chk("lbu_value", val32, 32'h0000_0080);
        op(1, 1, 0, 2'b01, 0, 5'd5, 1, 32'h102, 0);
        tick;
        chk("lh_value", val32, 32'hFFFF_80FF);
        op(1, 1, 0, 2'b01, 1, 5'd5, 1, 32'h102, 0);
        tick;
        chk("lhu_value", val32, 32'h0000_80FF);

        // stores
        op(1, 0, 1, 2'b01, 0, 5'd0, 0, 32'h202, 32'h1234_ABCD);
        rsp(1, 0, 0);
        @(negedge clk);
        chk("sh_write", b32.data_write_out, 1);
        chk("sh_read", b32.data_read_out, 0);
        chk("sh_mask", b32.data_write_mask_out, 4'b1100);
        chk("sh_wdata", b32.data_write_value_out, 32'hABCD_ABCD);
        tick;
        chk("sh_valid", valid32, 1);
        chk("sh_rdw", rdw32, 0);
        chk("sh_value", val32, 32'h202);
        op(1, 0, 1, 2'b10, 0, 5'd0, 0, 32'h201, 32'h55);
        @(negedge clk);
        chk("sb_mask", b32.data_write_mask_out, 4'b0010);
        chk("sb_wdata", b32.data_write_value_out, 32'h5555_5555);
        tick;

        // LW with three wait cycles
        op(1, 1, 0, 2'b00, 0, 5'd7, 1, 32'h300, 0);
        rsp(0, 0, 0);
        @(negedge clk);
        chk("lw_busy0", busy32, 1);
        chk("lw_read0", b32.data_read_out, 1);
        chk("lw_addr0", b32.data_address_out, 32'h300);
        tick;
        op(0, 0, 0, 2'b00, 0, 5'd0, 0, 32'hDEAD, 0);
        chk("lw_bubble", valid32, 0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("lw_busy", busy32, 1);
            chk("lw_read", b32.data_read_out, 1);
            chk("lw_addr", b32.data_address_out, 32'h300);
            chk("lw_mask", b32.data_write_mask_out, 4'b1111);
            tick;
            chk("lw_wait_valid", valid32, 0);
        end
        rsp(1, 32'hCAFE_BABE, 64'hCAFE_BABE);
        @(negedge clk);
        chk("lw_busy_rdy", busy32, 0);
        chk("lw_read_rdy", b32.data_read_out, 1);
        chk("lw_addr_rdy", b32.data_address_out, 32'h300);
        tick;
        chk("lw_valid", valid32, 1);
        chk("lw_rd", rd32, 7);
        chk("lw_rdw", rdw32, 1);
        chk("lw_value", val32, 32'hCAFE_BABE);
        rsp(0, 0, 0);
        @(negedge clk);
        chk("lw_busy_end", busy32, 0);
        chk("lw_read_end", b32.data_read_out, 0);
        tick;

        // ready while stalled -> DONE
        op(1, 1, 0, 2'b00, 0, 5'd9, 1, 32'h400, 0);
        tick;
        op(0, 0, 0, 2'b00, 0, 5'd0, 0, 32'h0, 0);
        stall = 1'b1;
        rsp(1, 32'h1122_3344, 64'h1122_3344);
        @(negedge clk);
        chk("st_busy_rdy", busy32, 0);
        tick;
        rsp(0, 0, 0);
        chk("st_valid0", valid32, 0);
        @(negedge clk);
        chk("st_read_done", b32.data_read_out, 0);
        chk("st_busy_done", busy32, 0);
        tick;
        chk("st_valid1", valid32, 0);
        stall = 1'b0;
        tick;
        chk("st_valid", valid32, 1);
        chk("st_rd", rd32, 9);
        chk("st_value", val32, 32'h1122_3344);

        // flush during WAIT
        op(1, 1, 0, 2'b00, 0, 5'd3, 1, 32'h500, 0);
        tick;
        op(0, 0, 0, 2'b00, 0, 5'd0, 0, 32'h0, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_busy", busy32, 1);
        chk("fl_read", b32.data_read_out, 1);
        tick;
        flush = 1'b0;
        rsp(1, 32'h5555_AAAA, 64'h5555_AAAA);
        @(negedge clk);
        chk("fl_read_rdy", b32.data_read_out, 1);
        tick;
        chk("fl_valid", valid32, 0);
        chk("fl_rdw", rdw32, 0);
        rsp(0, 0, 0);
        @(negedge clk);
        chk("fl_busy_end", busy32, 0);

        // flush in IDLE
        op(1, 1, 0, 2'b00, 0, 5'd2, 1, 32'h600, 0);
        flush = 1'b1;
        rsp(1, 32'h1, 64'h1);
        @(negedge clk);
        chk("fi_read", b32.data_read_out, 0);
        tick;
        chk("fi_valid", valid32, 0);
        chk("fi_rdw", rdw32, 0);
        flush = 1'b0;

        // non-memory op, then stall hold
        op(1, 0, 0, 2'b00, 0, 5'd4, 1, 32'h1234, 0);
        tick;
        chk("alu_valid", valid32, 1);
        chk("alu_rd", rd32, 4);
        chk("alu_value", val32, 32'h1234);
        stall = 1'b1;
        op(1, 0, 0, 2'b00, 0, 5'd6, 1, 32'h9999, 0);
        tick;
        chk("hold_rd", rd32, 4);
        chk("hold_value", val32, 32'h1234);
        stall = 1'b0;

        // double and word on XLEN=64
        op(1, 1, 0, 2'b11, 0, 5'd1, 1, 32'h8, 0);
        rsp(1, 32'h4433_2211, 64'h8877_6655_4433_2211);
        @(negedge clk);
        chk("ld_mask64", b64.data_write_mask_out, 8'hFF);
        chk("ld_read64", b64.data_read_out, 1);
        chk("ld_mask32", b32.data_write_mask_out, 4'b1111);
        tick;
        chk("ld_value64", val64, 64'h8877_6655_4433_2211);
        chk("ld_value32", val32, 32'h4433_2211);
        op(1, 1, 0, 2'b00, 0, 5'd1, 1, 32'hC, 0);
        rsp(1, 32'h9ABC_DEF0, 64'h9ABC_DEF0_0000_0000);
        @(negedge clk);
        chk("lw64_mask", b64.data_write_mask_out, 8'hF0);
        tick;
        chk("lw64_value", val64, 64'hFFFF_FFFF_9ABC_DEF0);
        chk("lw32_value", val32, 32'h9ABC_DEF0);

        // LW at 0x2
        op(1, 1, 0, 2'b00, 0, 5'd8, 1, 32'h2, 0);
        rsp(1, 32'h0BAD_F00D, 64'h0BAD_F00D_0BAD_F00D);
        @(negedge clk);
`ifdef RV_LSU_MISALIGN_TRAP_EN
        chk("mis_read", b32.data_read_out, 0);
        chk("mis_busy", busy32, 0);
        tick;
        chk("mis_flag", mis32, 1);
        chk("mis_valid", valid32, 1);
        chk("mis_rdw", rdw32, 0);
`else
        chk("mis_read", b32.data_read_out, 1);
        chk("mis_mask", b32.data_write_mask_out, 4'b1111);
        tick;
        chk("mis_flag", mis32, 0);
        chk("mis_rdw", rdw32, 1);
        chk("mis_value", val32, 32'h0BAD_F00D);
`endif

        // reset abandons a pending access
        op(1, 1, 0, 2'b00, 0, 5'd5, 1, 32'h700, 0);
        rsp(0, 0, 0);
        tick;
        op(0, 0, 0, 2'b00, 0, 5'd0, 0, 32'h0, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rw_busy", busy32, 0);
        chk("rw_read", b32.data_read_out, 0);
        chk("rw_valid", valid32, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
